// File: rtl/ntt_scheduler.sv
// Two-requester round-robin front end for a shared Full_NTT core: issues one job per cycle,
// tracks in-flight jobs with a tag FIFO and routes results back in issue order.
module ntt_scheduler #(
    parameter int unsigned N            = 8,
    parameter int unsigned CW           = 12,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic          clk,
    input  logic          r,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [CW-1:0] req0_coeffs    [N],
    input  logic [CW-1:0] req1_coeffs    [N],
    output logic          ntt_valid_in,
    output logic [CW-1:0] ntt_coeffs     [N],
    input  logic          ntt_valid_out,
    input  logic [CW-1:0] ntt_coeffs_out [N],
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [CW-1:0] rsp_coeffs     [N],
    output logic          busy,
    output logic          err
);

    localparam int unsigned PW   = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNTW = PW + 1;

    logic [CNTW-1:0]         cnt_q;
    logic [PW-1:0]           wr_q, rd_q;
    logic [MAX_INFLIGHT-1:0] tag_q;
    logic                    lg_q;

    logic full, grant0, grant1, accept, pop, head_tag;

    // A same-cycle return does not free a slot: full looks at the registered count only.
    assign full     = (cnt_q == CNTW'(MAX_INFLIGHT));
    assign grant0   = r & ~full & req0_valid & (~req1_valid | lg_q);
    assign grant1   = r & ~full & req1_valid & (~req0_valid | ~lg_q);
    assign accept   = grant0 | grant1;
    assign pop      = ntt_valid_out & (cnt_q != '0);
    assign head_tag = tag_q[rd_q];

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (cnt_q != '0) | ntt_valid_in;

    always_ff @(posedge clk) begin
        if (!r) begin
            cnt_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            tag_q        <= '0;
            lg_q         <= 1'b1;
            err          <= 1'b0;
            ntt_valid_in <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            ntt_coeffs   <= '{default: '0};
            rsp_coeffs   <= '{default: '0};
        end else begin
            ntt_valid_in <= accept;
            if (accept) begin
                tag_q[wr_q] <= grant1;
                wr_q        <= wr_q + PW'(1);
                lg_q        <= grant1;
                ntt_coeffs  <= grant1 ? req1_coeffs : req0_coeffs;
            end

            rsp0_valid <= pop & ~head_tag;
            rsp1_valid <= pop & head_tag;
            if (pop) begin
                rd_q       <= rd_q + PW'(1);
                rsp_coeffs <= ntt_coeffs_out;
            end

            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase

            // A result with nothing outstanding is dropped and flagged until reset.
            if (ntt_valid_out && cnt_q == '0) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_scheduler.sv
// Directed bench for ntt_scheduler: arbitration, issue/return ordering, full stall,
// spurious-return error flag and reset behaviour.
module tb_ntt_scheduler;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 12;
    localparam int unsigned M  = 4;

    logic          clk = 1'b0;
    logic          r;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [CW-1:0] req0_coeffs [N];
    logic [CW-1:0] req1_coeffs [N];
    logic          ntt_valid_in, ntt_valid_out;
    logic [CW-1:0] ntt_coeffs [N];
    logic [CW-1:0] ntt_coeffs_out [N];
    logic          rsp0_valid, rsp1_valid, busy, err;
    logic [CW-1:0] rsp_coeffs [N];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ntt_scheduler #(.N(N), .CW(CW), .MAX_INFLIGHT(M)) dut (
        .clk            (clk),
        .r              (r),
        .req0_valid     (req0_valid),
        .req1_valid     (req1_valid),
        .req0_ready     (req0_ready),
        .req1_ready     (req1_ready),
        .req0_coeffs    (req0_coeffs),
        .req1_coeffs    (req1_coeffs),
        .ntt_valid_in   (ntt_valid_in),
        .ntt_coeffs     (ntt_coeffs),
        .ntt_valid_out  (ntt_valid_out),
        .ntt_coeffs_out (ntt_coeffs_out),
        .rsp0_valid     (rsp0_valid),
        .rsp1_valid     (rsp1_valid),
        .rsp_coeffs     (rsp_coeffs),
        .busy           (busy),
        .err            (err)
    );

    function automatic logic [N*CW-1:0] pack_arr(input logic [CW-1:0] a [N]);
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = a[i];
        return v;
    endfunction

    function automatic logic [N*CW-1:0] seq(input int base);
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(base + i);
        return v;
    endfunction

    task automatic set_req(input int which, input int base);
        for (int i = 0; i < N; i++) begin
            if (which == 0) req0_coeffs[i] = CW'(base + i);
            else            req1_coeffs[i] = CW'(base + i);
        end
    endtask

    task automatic set_out(input int base);
        for (int i = 0; i < N; i++) ntt_coeffs_out[i] = CW'(base + i);
    endtask

    task automatic chk(input string tag, input logic [N*CW-1:0] obs, input logic [N*CW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int exp_tag [4];
        r = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0; ntt_valid_out = 1'b0;
        set_req(0, 1); set_req(1, 0); set_out(0);

        // Reset, with a request held valid to confirm it is not accepted.
        tick(); tick();
        settle();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_vin", ntt_valid_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_ntt_coeffs", pack_arr(ntt_coeffs), 0);
        chk("rst_rsp_coeffs", pack_arr(rsp_coeffs), 0);

        // Single request from requester 0 with 1..8.
        r = 1'b1;
        settle();
        chk("s1_ready0", req0_ready, 1);
        chk("s1_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("s1_vin", ntt_valid_in, 1);
        chk("s1_coeffs", pack_arr(ntt_coeffs), seq(1));
        chk("s1_busy", busy, 1);
        tick();
        chk("s1_vin_pulse", ntt_valid_in, 0);
        chk("s1_coeffs_hold", pack_arr(ntt_coeffs), seq(1));
        chk("s1_busy_inflight", busy, 1);
        ntt_valid_out = 1'b1; set_out(100);
        tick();
        ntt_valid_out = 1'b0;
        chk("s1_rsp", {rsp0_valid, rsp1_valid}, 2'b10);
        chk("s1_rsp_coeffs", pack_arr(rsp_coeffs), seq(100));
        tick();
        chk("s1_rsp_pulse", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("s1_idle", busy, 0);
        chk("s1_rsp_hold", pack_arr(rsp_coeffs), seq(100));

        // Fresh reset, then both requesters continuously valid: grants 0,1,0,1.
        r = 1'b0; tick(); r = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; set_req(0, 10); set_req(1, 20);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_vin", ntt_valid_in, 1);
            chk("rr_coeffs", pack_arr(ntt_coeffs), (k % 2 == 0) ? seq(10) : seq(20));
        end
        // Four in flight: full.
        chk("full_ready", {req0_ready, req1_ready}, 2'b00);
        tick();
        chk("full_ready2", {req0_ready, req1_ready}, 2'b00);
        chk("full_busy", busy, 1);
        chk("full_vin", ntt_valid_in, 0);
        ntt_valid_out = 1'b1; set_out(200);
        settle();
        chk("full_same_cycle", {req0_ready, req1_ready}, 2'b00);
        tick();
        ntt_valid_out = 1'b0;
        chk("full_rsp", {rsp0_valid, rsp1_valid}, 2'b10);
        chk("full_rsp_coeffs", pack_arr(rsp_coeffs), seq(200));
        // cnt now 3; last grant was 1, so requester 0 wins and refills the last slot.
        chk("free_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("refill_vin", ntt_valid_in, 1);
        chk("refill_coeffs", pack_arr(ntt_coeffs), seq(10));
        req0_valid = 1'b1;
        settle();
        chk("refull_ready", req0_ready, 0);
        req0_valid = 1'b0;
        // Drain: issue order was 1,0,1,0 after the first return.
        exp_tag = '{1, 0, 1, 0};
        for (int j = 0; j < 4; j++) begin
            ntt_valid_out = 1'b1; set_out(300 + 16 * j);
            tick();
            chk("drain_rsp", {rsp0_valid, rsp1_valid}, exp_tag[j] == 1 ? 2'b01 : 2'b10);
            chk("drain_coeffs", pack_arr(rsp_coeffs), seq(300 + 16 * j));
        end
        ntt_valid_out = 1'b0;
        tick();
        chk("drain_idle_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("drain_idle_busy", busy, 0);
        chk("drain_err", err, 0);

        // cnt = 2 (tags 1,0), then a same-cycle return and acceptance.
        req1_valid = 1'b1; set_req(1, 40);
        tick();
        req1_valid = 1'b0; req0_valid = 1'b1; set_req(0, 50);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; set_req(1, 60);
        ntt_valid_out = 1'b1; set_out(400);
        settle();
        chk("sim_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0; ntt_valid_out = 1'b0;
        chk("sim_rsp", {rsp0_valid, rsp1_valid}, 2'b01);
        chk("sim_vin", ntt_valid_in, 1);
        chk("sim_coeffs", pack_arr(ntt_coeffs), seq(60));
        // Remaining tags 0,1; a third return finds cnt == 0.
        ntt_valid_out = 1'b1; set_out(500); tick();
        chk("sim_rsp_a", {rsp0_valid, rsp1_valid}, 2'b10);
        ntt_valid_out = 1'b1; set_out(600); tick();
        chk("sim_rsp_b", {rsp0_valid, rsp1_valid}, 2'b01);
        chk("sim_rsp_b_coeffs", pack_arr(rsp_coeffs), seq(600));
        chk("sim_err_clear", err, 0);
        ntt_valid_out = 1'b1; set_out(900); tick();
        ntt_valid_out = 1'b0;
        chk("spur_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("spur_err", err, 1);
        chk("spur_coeffs_hold", pack_arr(rsp_coeffs), seq(600));
        tick(); tick();
        chk("spur_err_sticky", err, 1);
        chk("spur_busy", busy, 0);
        r = 1'b0; tick(); r = 1'b1;
        chk("spur_err_reset", err, 0);

        // Three jobs in flight, then reset mid-operation.
        req0_valid = 1'b1; set_req(0, 30);
        tick(); tick(); tick();
        req0_valid = 1'b0;
        chk("mid_busy", busy, 1);
        r = 1'b0; tick(); r = 1'b1;
        chk("mid_busy_rst", busy, 0);
        chk("mid_vin_rst", ntt_valid_in, 0);
        chk("mid_coeffs_rst", pack_arr(ntt_coeffs), 0);
        req1_valid = 1'b1; set_req(1, 70);
        settle();
        chk("mid_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("mid_vin", ntt_valid_in, 1);
        chk("mid_coeffs", pack_arr(ntt_coeffs), seq(70));
        ntt_valid_out = 1'b1; set_out(700); tick();
        ntt_valid_out = 1'b0;
        chk("mid_rsp", {rsp0_valid, rsp1_valid}, 2'b01);
        chk("mid_rsp_coeffs", pack_arr(rsp_coeffs), seq(700));
        tick();
        chk("mid_idle", busy, 0);
        chk("mid_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_scheduler.md
NTT_SCHEDULER -- requirements
Module: ntt_scheduler

Interface
REQ-001 SHALL have parameter N, default 8, meaning coefficients per transfer.
REQ-002 SHALL have parameter CW, default 12, meaning coefficient width in bits.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, meaning maximum outstanding NTT jobs, a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, width 1, meaning the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port r, input, width 1, meaning reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have ports req0_valid / req1_valid, input, width 1, meaning requester 0/1 has a job.
REQ-007 SHALL have ports req0_ready / req1_ready, output, width 1, meaning the job is accepted this cycle.
REQ-008 SHALL have ports req0_coeffs / req1_coeffs, input, N x CW unpacked array, meaning job input coefficients.
REQ-009 SHALL have port ntt_valid_in, output, width 1, meaning issue strobe to the shared Full_NTT.
REQ-010 SHALL have port ntt_coeffs, output, N x CW, meaning coefficients issued to Full_NTT.
REQ-011 SHALL have port ntt_valid_out, input, width 1, meaning result strobe from Full_NTT.
REQ-012 SHALL have port ntt_coeffs_out, input, N x CW, meaning the Full_NTT result.
REQ-013 SHALL have ports rsp0_valid / rsp1_valid, output, width 1, meaning a result for requester 0/1.
REQ-014 SHALL have port rsp_coeffs, output, N x CW, meaning the result data shared by both response strobes.
REQ-015 SHALL have port busy, output, width 1, meaning work is pending or in flight.
REQ-016 SHALL have port err, output, width 1, meaning a sticky flag for an unexpected ntt_valid_out.

Function
REQ-017 SHALL keep an in-flight counter cnt in the range 0..MAX_INFLIGHT: +1 on an accepted request, -1 on a matched ntt_valid_out, and unchanged when both happen in the same cycle.
REQ-018 SHALL drive both reqX_ready low when cnt == MAX_INFLIGHT, evaluated on the current cnt only (a same-cycle return does not free a slot).
REQ-019 SHALL accept at most one request per cycle; readiness is combinational from valids, cnt and the arbitration pointer.
REQ-020 SHALL arbitrate round-robin with a 1-bit pointer lg (last granted, reset 1): a single valid requester wins; with both valid, requester !lg wins; lg updates only on acceptance.
REQ-021 SHALL, on acceptance in cycle t, assert ntt_valid_in for exactly one cycle at t+1, with ntt_coeffs equal to the winner's coeffs sampled at t.
REQ-022 SHALL hold ntt_coeffs until the next issue.
REQ-023 SHALL push the winner id into a MAX_INFLIGHT-deep tag FIFO on acceptance, and pop it on ntt_valid_out when cnt > 0; results return in issue order.
REQ-024 SHALL, on ntt_valid_out at cycle t with cnt > 0, assert rsp<tag>_valid for exactly one cycle at t+1, with rsp_coeffs = ntt_coeffs_out sampled at t; rsp_coeffs is held until the next response.
REQ-025 SHALL treat a simultaneous push and pop as legal; the FIFO never overflows, per REQ-018.
REQ-026 SHALL, on ntt_valid_out with cnt == 0, produce no response, leave cnt at 0, and set err to 1 until reset.
REQ-027 SHALL drive busy = (cnt != 0) | ntt_valid_in.
REQ-028 SHALL never have both rsp0_valid and rsp1_valid high in the same cycle.

Reset
REQ-029 SHALL, while r == 0 at a clock edge, clear cnt, the FIFO pointers, err, busy, ntt_valid_in and rspX_valid, set lg = 1, and zero ntt_coeffs and rsp_coeffs.
REQ-030 SHALL hold reqX_ready at 0 during reset.
REQ-031 SHALL discard any jobs in flight on a mid-operation reset; Full_NTT shares r, so no stale result returns.

Verification
REQ-032 SHALL pass this scenario: req0 only with coeffs 1..8 -> ready at t, ntt_valid_in at t+1 with 1..8; on ntt_valid_out with data D -> rsp0_valid one cycle later with rsp_coeffs = D.
REQ-033 SHALL pass this scenario: both requesters valid continuously after reset -> grants alternate 0,1,0,1,...; responses return in the same order on rsp0/rsp1.
REQ-034 SHALL pass this scenario: 4 jobs issued with no returns -> both readies 0 and busy 1; one ntt_valid_out -> readies return the next cycle and cnt = 3.
REQ-035 SHALL pass this scenario: a return and an acceptance in the same cycle at cnt = 2 -> cnt stays 2 and tag order is preserved.
REQ-036 SHALL pass this scenario: ntt_valid_out pulsed with cnt = 0 -> no rspX_valid, err = 1 and stays 1; r = 0 for one cycle -> err = 0.
REQ-037 SHALL pass this scenario: r low with 3 jobs in flight -> next cycle cnt = 0, busy = 0, and a fresh req1 issue proceeds normally.
